traffic_sensor_conditioner: RTL and testbench

TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

---
 rtl/traffic_sensor_conditioner.sv | 135 +++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Conditions four raw loop-detector lines into per-lane traffic-density classes once per window.
// Optional: define SENSOR_HYSTERESIS_EN to let classes fall by at most one step per window.
module traffic_sensor_conditioner #(
  parameter int unsigned WINDOW_CYCLES   = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned THR_LOW         = 3,
  parameter int unsigned THR_MED         = 8,
  parameter int unsigned THR_HIGH        = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_north,
  input  logic       car_south,
  input  logic       car_east,
  input  logic       car_west,
  output logic [1:0] sensor_north,
  output logic [1:0] sensor_south,
  output logic [1:0] sensor_east,
  output logic [1:0] sensor_west,
  output logic       sample_valid
);

  localparam int unsigned NL    = 4;
  localparam int unsigned DB_W  = 8;
  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NL-1:0]    car_c;
  logic [NL-1:0]    sync1_q, sync1_d;
  logic [NL-1:0]    sync2_q, sync2_d;
  logic [NL-1:0]    deb_q, deb_d;
  logic [NL-1:0]    rise_q, rise_d;
  logic [DB_W-1:0]  stab_q [NL];
  logic [DB_W-1:0]  stab_d [NL];
  logic [CNT_W-1:0] cnt_q [NL];
  logic [CNT_W-1:0] cnt_d [NL];
  logic [1:0]       sensor_q [NL];
  logic [1:0]       sensor_d [NL];
  logic [WIN_W-1:0] win_q, win_d;
  logic             sample_valid_q, sample_valid_d;
  logic             window_end_c;

  assign car_c = {car_west, car_east, car_south, car_north};

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] c);
    if (c < CNT_W'(THR_LOW)) begin
      return 2'b00;
    end else if (c < CNT_W'(THR_MED)) begin
      return 2'b01;
    end else if (c < CNT_W'(THR_HIGH)) begin
      return 2'b10;
    end
    return 2'b11;
  endfunction

  always_comb begin
    sync1_d        = car_c;
    sync2_d        = sync1_q;
    deb_d          = deb_q;
    rise_d         = '0;
    window_end_c   = (win_q == WIN_LAST);
    win_d          = window_end_c ? '0 : win_q + WIN_W'(1);
    sample_valid_d = window_end_c;
    for (int i = 0; i < NL; i++) begin
      stab_d[i]   = '0;
      cnt_d[i]    = cnt_q[i];
      sensor_d[i] = sensor_q[i];

      // Level flips only on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
      if (sync2_q[i] != deb_q[i]) begin
        if (stab_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          stab_d[i] = stab_q[i] + DB_W'(1);
        end
      end
      rise_d[i] = deb_d[i] & ~deb_q[i];

      // An edge landing on window_end belongs to the new window.
      if (window_end_c) begin
        cnt_d[i] = rise_q[i] ? CNT_W'(1) : '0;
`ifdef SENSOR_HYSTERESIS_EN
        if (classify(cnt_q[i]) >= sensor_q[i]) begin
          sensor_d[i] = classify(cnt_q[i]);
        end else begin
          sensor_d[i] = sensor_q[i] - 2'd1;
        end
`else
        sensor_d[i] = classify(cnt_q[i]);
`endif
      end else if (rise_q[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      rise_q         <= '0;
      win_q          <= '0;
      sample_valid_q <= 1'b0;
      for (int i = 0; i < NL; i++) begin
        stab_q[i]   <= '0;
        cnt_q[i]    <= '0;
        sensor_q[i] <= 2'b00;
      end
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_q          <= deb_d;
      rise_q         <= rise_d;
      win_q          <= win_d;
      sample_valid_q <= sample_valid_d;
      for (int i = 0; i < NL; i++) begin
        stab_q[i]   <= stab_d[i];
        cnt_q[i]    <= cnt_d[i];
        sensor_q[i] <= sensor_d[i];
      end
    end
  end

  assign sensor_north = sensor_q[0];
  assign sensor_south = sensor_q[1];
  assign sensor_east  = sensor_q[2];
  assign sensor_west  = sensor_q[3];
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench: event-level vehicle model checked every cycle, plus literal window expectations.
`timescale 1ns/1ps
module tb_traffic_sensor_conditioner;

  // Window widened so a saturating burst fits inside one window.
  localparam int unsigned W    = 3200;
  localparam int unsigned D    = 4;
  localparam int unsigned CW   = 8;
  localparam int          SAT  = (1 << CW) - 1;
  localparam int          T_LO = 3;
  localparam int          T_MD = 8;
  localparam int          T_HI = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] car = 4'b0000;
  logic [1:0] s_n, s_s, s_e, s_w;
  logic       sv;

  traffic_sensor_conditioner #(
    .WINDOW_CYCLES  (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW),
    .THR_LOW        (T_LO),
    .THR_MED        (T_MD),
    .THR_HIGH       (T_HI)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .car_north   (car[0]),
    .car_south   (car[1]),
    .car_east    (car[2]),
    .car_west    (car[3]),
    .sensor_north(s_n),
    .sensor_south(s_s),
    .sensor_east (s_e),
    .sensor_west (s_w),
    .sample_valid(sv)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int printed  = 0;

  // Model: raw history per lane, vehicle events, windowed tallies.
  bit         hist [4][$];
  bit         lvl [4];
  bit         rise_p [4];
  int         cnt [4];
  int         exp_sensor [4];
  bit         exp_sv;
  logic [3:0] smp;

  function automatic int cls(input int c);
    if (c < T_LO) return 0;
    if (c < T_MD) return 1;
    if (c < T_HI) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist[i].delete();
      for (int k = 0; k < int'(D) + 2; k++) hist[i].push_back(1'b0);
      lvl[i]        = 1'b0;
      rise_p[i]     = 1'b0;
      cnt[i]        = 0;
      exp_sensor[i] = 0;
    end
    exp_sv = 1'b0;
    n      = 0;
  endtask

  // One clock edge: a lane's level flips once the input seen two edges ago
  // and the D-1 before it all disagree with it; a rise is tallied one edge later.
  task automatic model_step(input logic [3:0] c);
    bit all_diff;
    bit inc;
    int raw;
    n = n + 1;
    exp_sv = ((n % W) == 0);
    for (int i = 0; i < 4; i++) begin
      hist[i].push_back(c[i]);
      void'(hist[i].pop_front());
      inc = rise_p[i];
      all_diff = 1'b1;
      for (int k = 0; k < int'(D); k++) if (hist[i][k] == lvl[i]) all_diff = 1'b0;
      rise_p[i] = 1'b0;
      if (all_diff) begin
        lvl[i]    = ~lvl[i];
        rise_p[i] = lvl[i];
      end
      if ((n % W) == 0) begin
        raw = cls(cnt[i]);
`ifdef SENSOR_HYSTERESIS_EN
        exp_sensor[i] = (raw >= exp_sensor[i]) ? raw : exp_sensor[i] - 1;
`else
        exp_sensor[i] = raw;
`endif
        cnt[i] = inc ? 1 : 0;
      end else if (inc && cnt[i] < SAT) begin
        cnt[i] = cnt[i] + 1;
      end
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        smp = car;
        model_step(smp);
        #1;
        checks++;
        if (sv !== exp_sv || s_n !== 2'(exp_sensor[0]) || s_s !== 2'(exp_sensor[1]) ||
            s_e !== 2'(exp_sensor[2]) || s_w !== 2'(exp_sensor[3])) begin
          failures++;
          if (printed < 10) begin
            printed++;
            $display("FAIL cycle_model n=%0d: got valid=%b n/s/e/w=%0d/%0d/%0d/%0d, required valid=%b %0d/%0d/%0d/%0d",
                     n, sv, s_n, s_s, s_e, s_w, exp_sv,
                     exp_sensor[0], exp_sensor[1], exp_sensor[2], exp_sensor[3]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (n != target && guard < 2 * int'(W)) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) begin
      checks++;
      failures++;
      $display("FAIL wait_n: reached n=%0d, required %0d", n, target);
    end
  endtask

  task automatic pulses(input logic [3:0] mask, input int num, input int hi, input int lo);
    for (int p = 0; p < num; p++) begin
      car = car | mask;
      repeat (hi) @(negedge clk);
      car = car & ~mask;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic chk_lanes(input string tag, input int en, input int es, input int ee, input int ew);
    chk({tag, "_valid"}, int'(sv), 1);
    chk({tag, "_north"}, int'(s_n), en);
    chk({tag, "_south"}, int'(s_s), es);
    chk({tag, "_east"},  int'(s_e), ee);
    chk({tag, "_west"},  int'(s_w), ew);
  endtask

  int hyst_exp [3];

  initial begin
`ifdef SENSOR_HYSTERESIS_EN
    hyst_exp = '{2, 1, 0};
`else
    hyst_exp = '{0, 0, 0};
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({sv, s_n, s_s, s_e, s_w}), 0);
    rst = 1'b0;

    // Window 1: five clean north vehicles; east glitches rejected, three 4-cycle pulses accepted.
    pulses(4'b0001, 5, 10, 10);
    pulses(4'b0100, 20, 3, 7);
    pulses(4'b0100, 3, 4, 6);
    wait_n(W);
    chk_lanes("w1", 1, 0, 1, 0);

    // Window 2: 258 south vehicles, so a wrapping counter would fall to class 00.
    pulses(4'b0010, 258, 5, 5);
    wait_n(2 * W);
    chk_lanes("w2_saturate", 0, 3, 0, 0);

    // Mid-window reset with counts pending and north held high across release.
    pulses(4'b0001, 3, 5, 5);
    wait_n(2 * W + 500);
    car[0] = 1'b1;
    rst    = 1'b1;
    #1;
    chk("async_reset_outputs", int'({sv, s_n, s_s, s_e, s_w}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    car[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Window A: north 1+2+2, south 2+1, east 2+1, west 2 plus one debounced on window_end.
    pulses(4'b0001, 2, 5, 5);
    pulses(4'b1111, 2, 5, 5);
    pulses(4'b0110, 1, 5, 5);
    wait_n(W - 7);
    car[3] = 1'b1;
    wait_n(W - 1);
    chk("first_valid_not_early", int'(sv), 0);
    wait_n(W);
    chk_lanes("wA", 1, 1, 1, 0);
    repeat (4) @(negedge clk);
    car[3] = 1'b0;
    repeat (10) @(negedge clk);

    // Window B: west starts at 1 from the boundary edge, plus two more.
    pulses(4'b1000, 2, 5, 5);
    wait_n(2 * W);
    chk_lanes("wB_boundary", 0, 0, 0, 1);

    // Window C: 20 north vehicles, then empty windows.
    pulses(4'b0001, 20, 5, 5);
    wait_n(3 * W);
    chk_lanes("wC_busy", 3, 0, 0, 0);
    wait_n(4 * W);
    chk("wD_north", int'(s_n), hyst_exp[0]);
    wait_n(5 * W);
    chk("wE_north", int'(s_n), hyst_exp[1]);
    wait_n(6 * W);
    chk("wF_north", int'(s_n), hyst_exp[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
